// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display read-back block:
//   - SEG_0..SEG_9, SEG_BLANK : active-high segment patterns (bit0=a .. bit6=g)
//   - cap_state_t            : capture FSM states
//   - bcd_t                  : one decoded BCD digit
//   - is_onehot8()           : exactly-one-bit-set test for the digit strobe
// ----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_t;

  typedef logic [3:0] bcd_t;

  // True when exactly one bit of v is set (active-high strobe view).
  function automatic logic is_onehot8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return (n == 4'd1);
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// ----------------------------------------------------------------------------
// seg7_pattern_decoder
// Combinational decode of an active-high segment pattern back to BCD.
//   pat_i   [6:0] in  : active-high segments, bit0=a .. bit6=g
//   value_o [3:0] out : decoded digit (0 for blank or unrecognised)
//   blank_o       out : all segments off
//   error_o       out : pattern is neither a digit nor blank
// ----------------------------------------------------------------------------
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output bcd_t       value_o,
  output logic       blank_o,
  output logic       error_o
);

  // Pattern lookup; blank is a legal state, not an error.
  always_comb begin
    value_o = 4'd0;
    blank_o = 1'b0;
    error_o = 1'b0;
    case (pat_i)
      SEG_0:     value_o = 4'd0;
      SEG_1:     value_o = 4'd1;
      SEG_2:     value_o = 4'd2;
      SEG_3:     value_o = 4'd3;
      SEG_4:     value_o = 4'd4;
      SEG_5:     value_o = 4'd5;
      SEG_6:     value_o = 4'd6;
      SEG_7:     value_o = 4'd7;
      SEG_8:     value_o = 4'd8;
      SEG_9:     value_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// ----------------------------------------------------------------------------
// seven_segment_capture
// Reads back a multiplexed active-low 7-segment bus and rebuilds an 8-digit
// snapshot of BCD values, blank flags and error flags.
//   clock          in  : system clock, all state on posedge
//   reset_L        in  : asynchronous active-low reset
//   seg_n     [6:0] in : segment lines, active-low (bit0=a .. bit6=g)
//   dig_sel_n [7:0] in : digit strobe, active-low one-hot
//   bcd_out  [31:0] out: digit i value in [4i+3:4i]
//   blank_out [7:0] out: digit i captured blank
//   err_out   [7:0] out: digit i captured with unrecognised pattern
//   capture        out : pulse, one digit latched
//   frame_done     out : pulse, all 8 digits latched since last frame_done
//   sel_fault      out : pulse, sampled strobe not one-hot
// A digit is latched once its strobe and segments have been stable for
// STABLE_CYCLES sampled cycles; it is not re-latched until the dwell changes.
// ----------------------------------------------------------------------------
module seven_segment_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [6:0]  seg_n,
  input  logic [7:0]  dig_sel_n,
  output logic [31:0] bcd_out,
  output logic [7:0]  blank_out,
  output logic [7:0]  err_out,
  output logic        capture,
  output logic        frame_done,
  output logic        sel_fault
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  // Sample stage is kept active-high: 0 means "strobe idle / segments off".
  logic [7:0]    sel_q, sel_prev_q;
  logic [6:0]    pat_q, pat_prev_q;
  cap_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   bcd_q;
  logic [7:0]    blank_q, err_q;
  logic          capture_q, frame_done_q, sel_fault_q;

  logic          onehot_s, same_s, cap_s, frame_s;
  logic [2:0]    idx_s;
  logic [7:0]    seen_set_s;
  bcd_t          dec_value_s;
  logic          dec_blank_s, dec_error_s;

  seg7_pattern_decoder u_dec (
    .pat_i   (pat_q),
    .value_o (dec_value_s),
    .blank_o (dec_blank_s),
    .error_o (dec_error_s)
  );

  // Strobe qualification, change detection and digit index.
  always_comb begin
    onehot_s = is_onehot8(sel_q);
    same_s   = (sel_q == sel_prev_q) && (pat_q == pat_prev_q);
    idx_s    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      // OR-reduction is exact because idx_s is only used when sel_q is one-hot.
      idx_s = idx_s | (sel_q[i] ? 3'(i) : 3'd0);
    end
  end

  // Next-state / dwell counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_s   = 1'b0;
    case (state_q)
      WAIT: begin
        if (onehot_s) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!onehot_s) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (same_s) begin
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
          cnt_d   = CW'(1);
        end
      end
      HOLD: begin
        if (!onehot_s) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (!same_s) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
    // Reaching the threshold (including on the first cycle when it is 1) latches.
    if (state_d == SETTLE && cnt_d == CNT_MAX) begin
      cap_s   = 1'b1;
      state_d = HOLD;
    end else begin
      cap_s   = 1'b0;
    end
  end

  // Seen-mask bookkeeping; a completing capture clears the mask for the next frame.
  always_comb begin
    seen_set_s = seen_q | sel_q;
    frame_s    = cap_s && (seen_set_s == 8'hFF);
    if (frame_s) begin
      seen_d = 8'h00;
    end else if (cap_s) begin
      seen_d = seen_set_s;
    end else begin
      seen_d = seen_q;
    end
  end

  // Sample stage, FSM state, digit storage and registered pulse outputs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sel_q        <= 8'h00;
      sel_prev_q   <= 8'h00;
      pat_q        <= 7'h00;
      pat_prev_q   <= 7'h00;
      state_q      <= WAIT;
      cnt_q        <= '0;
      seen_q       <= 8'h00;
      bcd_q        <= 32'h0;
      blank_q      <= 8'h00;
      err_q        <= 8'h00;
      capture_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sel_fault_q  <= 1'b0;
    end else begin
      sel_q        <= ~dig_sel_n;
      pat_q        <= ~seg_n;
      sel_prev_q   <= sel_q;
      pat_prev_q   <= pat_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      capture_q    <= cap_s;
      frame_done_q <= frame_s;
      sel_fault_q  <= ~onehot_s;
      if (cap_s) begin
        bcd_q[{idx_s, 2'b00} +: 4] <= dec_value_s;
        blank_q[idx_s]             <= dec_blank_s;
        err_q[idx_s]               <= dec_error_s;
      end
    end
  end

  assign bcd_out    = bcd_q;
  assign blank_out  = blank_q;
  assign err_out    = err_q;
  assign capture    = capture_q;
  assign frame_done = frame_done_q;
  assign sel_fault  = sel_fault_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

  localparam int STABLE = 4;

  logic        clock = 1'b0;
  logic        reset_L;
  logic [6:0]  seg_n;
  logic [7:0]  dig_sel_n;
  logic [31:0] bcd_out;
  logic [7:0]  blank_out, err_out;
  logic        capture, frame_done, sel_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .seg_n      (seg_n),
    .dig_sel_n  (dig_sel_n),
    .bcd_out    (bcd_out),
    .blank_out  (blank_out),
    .err_out    (err_out),
    .capture    (capture),
    .frame_done (frame_done),
    .sel_fault  (sel_fault)
  );

  // ---------------- reference model (run-length view of the sampled bus) ----
  logic [6:0] pats [10];
  logic [7:0] m_sel, m_prev_sel;
  logic [6:0] m_seg, m_prev_seg;
  int         run;
  logic [3:0] m_val [8];
  logic [7:0] m_blank, m_err, m_seen;
  logic       e_cap, e_frame, e_fault;

  function automatic void decode(input logic [6:0] p, output logic [3:0] v,
                                 output logic b, output logic e);
    v = 4'd0;
    b = (p == 7'h00);
    e = !b;
    for (int k = 0; k < 10; k++) begin
      if (p == pats[k]) begin
        v = 4'(k);
        e = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] m_bcd();
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = m_val[i];
    return r;
  endfunction

  task automatic model_reset();
    m_sel = 8'hFF; m_prev_sel = 8'hFF;
    m_seg = 7'h7F; m_prev_seg = 7'h7F;
    run = 0;
    for (int i = 0; i < 8; i++) m_val[i] = 4'd0;
    m_blank = 8'h00; m_err = 8'h00; m_seen = 8'h00;
    e_cap = 1'b0; e_frame = 1'b0; e_fault = 1'b0;
  endtask

  // Called just after a rising edge: evaluates the sample taken one edge earlier.
  task automatic model_step();
    logic       oh, b, e;
    logic [3:0] v;
    int         d;
    oh      = ($countones(~m_sel) == 1);
    e_fault = !oh;
    e_cap   = 1'b0;
    e_frame = 1'b0;
    if (!oh) run = 0;
    else if (run > 0 && m_sel == m_prev_sel && m_seg == m_prev_seg) run++;
    else run = 1;
    if (oh && run == STABLE) begin
      e_cap = 1'b1;
      d = 0;
      for (int i = 0; i < 8; i++) if (!m_sel[i]) d = i;
      decode(~m_seg, v, b, e);
      m_val[d] = v; m_blank[d] = b; m_err[d] = e; m_seen[d] = 1'b1;
      if (m_seen == 8'hFF) begin
        e_frame = 1'b1;
        m_seen  = 8'h00;
      end
    end
    m_prev_sel = m_sel; m_prev_seg = m_seg;
    m_sel = dig_sel_n;  m_seg = seg_n;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("capture",    {31'd0, capture},    {31'd0, e_cap});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_frame});
    chk("sel_fault",  {31'd0, sel_fault},  {31'd0, e_fault});
    chk("bcd_out",    bcd_out,             m_bcd());
    chk("blank_out",  {24'd0, blank_out},  {24'd0, m_blank});
    chk("err_out",    {24'd0, err_out},    {24'd0, m_err});
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cyc(input logic [7:0] sel, input logic [6:0] seg);
    dig_sel_n = sel;
    seg_n     = seg;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(8'hFF, 7'h7F);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bcd"},   bcd_out, 32'h0);
    chk({tag, "_blank"}, {24'd0, blank_out}, 32'h0);
    chk({tag, "_err"},   {24'd0, err_out}, 32'h0);
    chk({tag, "_pulses"}, {29'd0, capture, frame_done, sel_fault}, 32'h0);
  endtask

  typedef struct {
    logic [7:0] sel;
    logic [6:0] seg;
    int         dig;
    logic [3:0] val;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int first, ncap, nframe, nfault;
    logic [7:0] rs;
    logic [6:0] rp;
    int         hold, r;

    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    tbl[0]  = '{8'hFE, ~7'h3F, 0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'hFD, ~7'h06, 1, 4'd1, 1'b0, 1'b0};
    tbl[2]  = '{8'hFB, ~7'h5B, 2, 4'd2, 1'b0, 1'b0};
    tbl[3]  = '{8'hF7, ~7'h4F, 3, 4'd3, 1'b0, 1'b0};
    tbl[4]  = '{8'hEF, ~7'h66, 4, 4'd4, 1'b0, 1'b0};
    tbl[5]  = '{8'hDF, ~7'h6D, 5, 4'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'hBF, ~7'h7D, 6, 4'd6, 1'b0, 1'b0};
    tbl[7]  = '{8'h7F, ~7'h07, 7, 4'd7, 1'b0, 1'b0};
    tbl[8]  = '{8'hFE, ~7'h7F, 0, 4'd8, 1'b0, 1'b0};
    tbl[9]  = '{8'hFD, ~7'h6F, 1, 4'd9, 1'b0, 1'b0};
    tbl[10] = '{8'hF7, 7'h7F,  3, 4'd0, 1'b1, 1'b0};
    tbl[11] = '{8'hEF, ~7'h01, 4, 4'd0, 1'b0, 1'b1};
    tbl[12] = '{8'hBF, 7'h00,  6, 4'd8, 1'b0, 1'b0};
    tbl[13] = '{8'h7F, ~7'h77, 7, 4'd0, 1'b0, 1'b1};

    // Power-on reset
    reset_L = 1'b0; dig_sel_n = 8'hFF; seg_n = 7'h7F;
    model_reset();
    @(negedge clock); @(negedge clock);
    check_all_zero("reset");
    reset_L = 1'b1;
    gap(3);

    // Single digit: value 2 on digit 0, capture on the 5th cycle only
    first = 0; ncap = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(8'hFE, ~7'h5B);
      if (capture) begin ncap++; if (first == 0) first = k; end
    end
    chk("single_cap_cycle", 32'(first), 32'd5);
    chk("single_cap_count", 32'(ncap), 32'd1);
    chk("single_value", {28'd0, bcd_out[3:0]}, 32'd2);
    gap(2);

    // Glitch: 3 cycles of '1' then '3' on digit 1; capture 4 stable cycles after change
    first = 0; ncap = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(8'hFD, (k <= 3) ? ~7'h06 : ~7'h4F);
      if (capture) begin ncap++; if (first == 0) first = k; end
    end
    chk("glitch_cap_cycle", 32'(first), 32'd8);
    chk("glitch_cap_count", 32'(ncap), 32'd1);
    chk("glitch_value", {28'd0, bcd_out[7:4]}, 32'd3);

    // Asynchronous reset mid-dwell
    cyc(8'hFB, ~7'h66);
    cyc(8'hFB, ~7'h66);
    #2 reset_L = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clock);
    dig_sel_n = 8'hFF; seg_n = 7'h7F;
    reset_L = 1'b1;
    ncap = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(8'hFF, 7'h7F);
      if (capture) ncap++;
    end
    chk("release_no_capture", 32'(ncap), 32'd0);

    // Full frame: digits 0..7 carry 7..0
    nframe = 0;
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 5; k++) begin
        cyc(~(8'd1 << d), ~pats[7-d]);
        if (frame_done) nframe++;
        if (d == 7 && capture) chk("frame_coincident", {31'd0, frame_done}, 32'd1);
      end
    end
    chk("frame_count", 32'(nframe), 32'd1);
    chk("frame_bcd", bcd_out, 32'h0123_4567);
    gap(1);

    // Table-driven decode including blank / error / all-on
    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < 5; k++) cyc(tbl[t].sel, tbl[t].seg);
      gap(1);
      chk("tbl_val",   {28'd0, bcd_out[4*tbl[t].dig +: 4]}, {28'd0, tbl[t].val});
      chk("tbl_blank", {31'd0, blank_out[tbl[t].dig]},      {31'd0, tbl[t].blank});
      chk("tbl_err",   {31'd0, err_out[tbl[t].dig]},        {31'd0, tbl[t].err});
    end

    // Strobe faults: two strobes active, then all idle
    nfault = 0; ncap = 0;
    for (int k = 0; k < 6; k++) begin
      cyc((k < 3) ? 8'hFC : 8'hFF, ~7'h06);
      if (sel_fault) nfault++;
      if (capture) ncap++;
    end
    chk("fault_pulses", 32'(nfault), 32'd6);
    chk("fault_no_capture", 32'(ncap), 32'd0);
    chk("fault_data_kept", bcd_out, m_bcd());

    // Randomized dwells against the model
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 11);
      if (r < 10) rp = ~pats[r];
      else if (r == 10) rp = 7'h7F;
      else rp = 7'($urandom);
      if ($urandom_range(0, 7) == 0) rs = 8'($urandom);
      else rs = ~(8'd1 << $urandom_range(0, 7));
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) cyc(rs, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
